// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC and runs a one-outstanding req/ack fetch to imem.
// Optional perf counters are built when FETCH_PERF_EN is defined.
module fetch_ctrl #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        branch,
    input  logic [15:0] branch_PC,
    input  logic        stall,
    input  logic        halt,
    input  logic        imem_rdy,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    output logic [15:0] instr,
    output logic        instr_valid,
    output logic [15:0] seq_PC,
    output logic        halted
`ifdef FETCH_PERF_EN
   ,output logic [15:0] perf_fetch_cnt,
    output logic [15:0] perf_stall_cnt
`endif
);

    localparam int unsigned W = 16;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   pc;
    logic           drop;
    logic           halt_go, stall_go;
    logic           redirect, capture, drop_set, drop_clr, halt_enter;

    // Redirect outranks both halt and stall; they only act on a valid instr.
    assign halt_go  = halt  & instr_valid & ~branch;
    assign stall_go = stall & instr_valid & ~branch;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and datapath strobes
    always_comb begin
        state_nxt  = state;
        redirect   = 1'b0;
        capture    = 1'b0;
        drop_set   = 1'b0;
        drop_clr   = 1'b0;
        halt_enter = 1'b0;
        case (state)
            S_FETCH: begin
                if (branch) begin
                    redirect = 1'b1;
                    if (imem_rdy) begin
                        drop_set  = 1'b1;
                        state_nxt = S_WAIT;
                    end
                end else if (halt_go) begin
                    halt_enter = 1'b1;
                    state_nxt  = S_HALT;
                end else if (stall_go) begin
                    state_nxt = S_HOLD;
                end else if (imem_rdy) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (branch) begin
                    redirect = 1'b1;
                    if (imem_ack) begin
                        drop_clr  = 1'b1;
                        state_nxt = S_FETCH;
                    end else begin
                        drop_set = 1'b1;
                    end
                end else if (halt_go) begin
                    halt_enter = 1'b1;
                    drop_clr   = 1'b1;
                    state_nxt  = S_HALT;
                end else if (imem_ack) begin
                    state_nxt = S_FETCH;
                    if (drop) begin
                        drop_clr = 1'b1;
                    end else begin
                        capture = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (branch) begin
                    redirect  = 1'b1;
                    state_nxt = S_FETCH;
                end else if (halt_go) begin
                    halt_enter = 1'b1;
                    state_nxt  = S_HALT;
                end else if (!stall) begin
                    state_nxt = S_FETCH;
                end
            end
            S_HALT: begin
                state_nxt = S_HALT;
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

    // Memory-side outputs; request suppressed while in reset or when held/halting
    always_comb begin
        imem_req  = rst_n & (state == S_FETCH) & ~halt_go & ~stall_go;
        imem_addr = pc;
    end

    // PC, instruction register and drop flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            instr       <= NOP_INSTR;
            instr_valid <= 1'b0;
            seq_PC      <= W'(RESET_PC + 16'd2);
            halted      <= 1'b0;
            drop        <= 1'b0;
        end else begin
            if (redirect) begin
                pc          <= branch_PC & 16'hFFFE;
                instr_valid <= 1'b0;
                instr       <= NOP_INSTR;
            end else if (halt_enter) begin
                halted      <= 1'b1;
                instr_valid <= 1'b0;
                instr       <= NOP_INSTR;
            end else if (capture) begin
                instr       <= imem_data;
                instr_valid <= 1'b1;
                seq_PC      <= W'(pc + 16'd2);
                pc          <= W'(pc + 16'd2);
            end
            if (drop_set) begin
                drop <= 1'b1;
            end else if (drop_clr) begin
                drop <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_EN
    // Saturating counters: accepted instructions and cycles spent waiting or held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= 16'h0000;
            perf_stall_cnt <= 16'h0000;
        end else begin
            if (capture && (perf_fetch_cnt != 16'hFFFF)) begin
                perf_fetch_cnt <= W'(perf_fetch_cnt + 16'd1);
            end
            if (((state == S_HOLD) || (state == S_WAIT)) && (perf_stall_cnt != 16'hFFFF)) begin
                perf_stall_cnt <= W'(perf_stall_cnt + 16'd1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl with hand-computed expectations.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        branch;
    logic [15:0] branch_PC;
    logic        stall;
    logic        halt;
    logic        imem_rdy;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] instr;
    logic        instr_valid;
    logic [15:0] seq_PC;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetch_cnt;
    logic [15:0] perf_stall_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    fetch_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .branch      (branch),
        .branch_PC   (branch_PC),
        .stall       (stall),
        .halt        (halt),
        .imem_rdy    (imem_rdy),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .instr       (instr),
        .instr_valid (instr_valid),
        .seq_PC      (seq_PC),
        .halted      (halted)
`ifdef FETCH_PERF_EN
       ,.perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 2 time units after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0; branch = 1'b0; branch_PC = 16'h0000; stall = 1'b0; halt = 1'b0;
        imem_rdy = 1'b0; imem_ack = 1'b0; imem_data = 16'h0000;
        tick(); tick();

        // Reset state
        chk("rst_req",   16'(imem_req), 16'h0000);
        chk("rst_instr", instr, 16'h0800);
        chk("rst_valid", 16'(instr_valid), 16'h0000);
        chk("rst_seq",   seq_PC, 16'h0002);
        chk("rst_halt",  16'(halted), 16'h0000);
        chk("rst_addr",  imem_addr, 16'h0000);
        rst_n = 1'b1;
        #1;

        // 1. Basic fetch with 1-cycle ack latency
        chk("t1_req",  16'(imem_req), 16'h0001);
        chk("t1_addr", imem_addr, 16'h0000);
        imem_rdy = 1'b1;
        tick();
        imem_rdy = 1'b0; imem_ack = 1'b1; imem_data = 16'hC123;
        #1;
        chk("t1_wait_req", 16'(imem_req), 16'h0000);
        tick();
        imem_ack = 1'b0;
        #1;
        chk("t1_instr", instr, 16'hC123);
        chk("t1_valid", 16'(instr_valid), 16'h0001);
        chk("t1_seq",   seq_PC, 16'h0002);
        chk("t1_naddr", imem_addr, 16'h0002);
        chk("t1_nreq",  16'(imem_req), 16'h0001);

        // 2. Stall for 3 cycles while instr is valid
        stall = 1'b1;
        #1;
        chk("t2_req0", 16'(imem_req), 16'h0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_req",   16'(imem_req), 16'h0000);
            chk("t2_instr", instr, 16'hC123);
            chk("t2_seq",   seq_PC, 16'h0002);
        end
        stall = 1'b0;
        #1;
        chk("t2_drop_req", 16'(imem_req), 16'h0000);
        tick();
        chk("t2_resume_req",  16'(imem_req), 16'h0001);
        chk("t2_resume_addr", imem_addr, 16'h0002);

        // 3. Redirect while waiting; the late ack is dropped
        imem_rdy = 1'b1;
        tick();
        imem_rdy = 1'b0; branch = 1'b1; branch_PC = 16'h0041;
        tick();
        branch = 1'b0;
        #1;
        chk("t3_valid", 16'(instr_valid), 16'h0000);
        chk("t3_instr", instr, 16'h0800);
        chk("t3_req",   16'(imem_req), 16'h0000);
        imem_ack = 1'b1; imem_data = 16'hFFFF;
        tick();
        imem_ack = 1'b0;
        #1;
        chk("t3_valid2", 16'(instr_valid), 16'h0000);
        chk("t3_instr2", instr, 16'h0800);
        chk("t3_req2",   16'(imem_req), 16'h0001);
        chk("t3_addr",   imem_addr, 16'h0040);

        // 4. PC wrap at 0xFFFE, reached via redirect in FETCH without acceptance
        branch = 1'b1; branch_PC = 16'hFFFF;
        tick();
        branch = 1'b0;
        #1;
        chk("t4_addr", imem_addr, 16'hFFFE);
        chk("t4_req",  16'(imem_req), 16'h0001);
        imem_rdy = 1'b1;
        tick();
        imem_rdy = 1'b0; imem_ack = 1'b1; imem_data = 16'h1234;
        tick();
        imem_ack = 1'b0;
        #1;
        chk("t4_instr", instr, 16'h1234);
        chk("t4_valid", 16'(instr_valid), 16'h0001);
        chk("t4_seq",   seq_PC, 16'h0000);
        chk("t4_naddr", imem_addr, 16'h0000);

        // Redirect in FETCH coincident with acceptance: that request's data is dropped
        branch = 1'b1; branch_PC = 16'h0100; imem_rdy = 1'b1;
        tick();
        branch = 1'b0; imem_rdy = 1'b0; imem_ack = 1'b1; imem_data = 16'hAAAA;
        tick();
        imem_ack = 1'b0;
        #1;
        chk("tf_valid", 16'(instr_valid), 16'h0000);
        chk("tf_instr", instr, 16'h0800);
        chk("tf_addr",  imem_addr, 16'h0100);

        // 5. Halt with branch: redirect wins; then halt alone
        imem_rdy = 1'b1;
        tick();
        imem_rdy = 1'b0; imem_ack = 1'b1; imem_data = 16'h5555;
        tick();
        imem_ack = 1'b0;
        #1;
        chk("t5_instr", instr, 16'h5555);
        chk("t5_seq",   seq_PC, 16'h0102);
        halt = 1'b1; branch = 1'b1; branch_PC = 16'h0200;
        tick();
        halt = 1'b0; branch = 1'b0;
        #1;
        chk("t5_halted0", 16'(halted), 16'h0000);
        chk("t5_addr",    imem_addr, 16'h0200);
        chk("t5_valid",   16'(instr_valid), 16'h0000);
        imem_rdy = 1'b1;
        tick();
        imem_rdy = 1'b0; imem_ack = 1'b1; imem_data = 16'h7777;
        tick();
        imem_ack = 1'b0;
        halt = 1'b1;
        #1;
        chk("t5_instr2", instr, 16'h7777);
        chk("t5_hreq",   16'(imem_req), 16'h0000);
        tick();
        halt = 1'b0; imem_rdy = 1'b1; branch = 1'b1; branch_PC = 16'h0300;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("t5_halt_req", 16'(imem_req), 16'h0000);
            chk("t5_halted",   16'(halted), 16'h0001);
            tick();
        end
        branch = 1'b0; imem_rdy = 1'b0;
        chk("t5_hvalid", 16'(instr_valid), 16'h0000);
        chk("t5_haddr",  imem_addr, 16'h0202);

        // 6. Reset mid-transaction; the late ack is ignored
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("t6_halted", 16'(halted), 16'h0000);
        imem_rdy = 1'b1;
        tick();
        imem_rdy = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_req", 16'(imem_req), 16'h0000);
        tick();
        rst_n = 1'b1;
        imem_ack = 1'b1; imem_data = 16'hDEAD;
        tick();
        imem_ack = 1'b0;
        #1;
        chk("t6_valid", 16'(instr_valid), 16'h0000);
        chk("t6_instr", instr, 16'h0800);
        chk("t6_addr",  imem_addr, 16'h0000);
        chk("t6_req",   16'(imem_req), 16'h0001);
`ifdef FETCH_PERF_EN
        chk("t6_pfetch", perf_fetch_cnt, 16'h0000);
        chk("t6_pstall", perf_stall_cnt, 16'h0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
